mc_mem_access: RTL and testbench

- Memory access sequencer for the multicycle MIPS core; sits between the control unit/datapath and the single-port word RAM.
- Accepts one fetch, load or store request at a time and latches address and write data.
- Drives the RAM's address, read-enable, write-enable and write-data for a programmable number of cycles.
- Captures read data into the instruction register (IR) or memory data register (MDR), then reports done or error.

---
 rtl/mc_mem_access.sv | 121 ++++++++++++
 tb/tb_mc_mem_access.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_access.sv
// Multicycle-MIPS RAM sequencer: fetch/load/store with IR/MDR capture; MEM_PERF_CNT_EN adds access counters.
// Done arrives WAIT_CYCLES+1 cycles after accept; no backpressure, req is only sampled in IDLE.
module mc_mem_access #(
   parameter int AddrWidth   = 32,
   parameter int DataWidth   = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_LIMIT  = 1024
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 req,
   input  logic [1:0]           op,
   input  logic [AddrWidth-1:0] addr_in,
   input  logic [DataWidth-1:0] wdata_in,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [DataWidth-1:0] ir,
   output logic [DataWidth-1:0] mdr,
   output logic [AddrWidth-1:0] mem_Addr,
   output logic                 mem_R,
   output logic                 mem_W,
   output logic [DataWidth-1:0] mem_W_data,
`ifdef MEM_PERF_CNT_EN
   output logic [31:0]          fetch_cnt,
   output logic [31:0]          load_cnt,
   output logic [31:0]          store_cnt,
   output logic [31:0]          err_cnt,
`endif
   input  logic [DataWidth-1:0] mem_R_data
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

   localparam logic [1:0]           OP_FETCH = 2'b00;
   localparam logic [1:0]           OP_LOAD  = 2'b01;
   localparam logic [1:0]           OP_STORE = 2'b10;
   localparam logic [1:0]           OP_RSVD  = 2'b11;
   localparam logic [3:0]           CNT_INIT = 4'(WAIT_CYCLES - 1);
   localparam logic [AddrWidth-1:0] ADDR_LIM = AddrWidth'(ADDR_LIMIT);

   state_t     state, state_nxt;
   logic [1:0] op_q;
   logic [3:0] cnt;
   logic       req_bad;
   logic       start;
   logic       last;

   assign req_bad = (addr_in[1:0] != 2'b00) || (addr_in >= ADDR_LIM) || (op == OP_RSVD);
   assign start   = (state == S_IDLE) && req && !req_bad;
   assign last    = (state == S_ACCESS) && (cnt == 4'd0);

   assign busy = (state == S_ACCESS);
   assign done = (state == S_DONE);
   assign err  = (state == S_ERR);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (req) state_nxt = req_bad ? S_ERR : S_ACCESS;
         S_ACCESS: if (cnt == 4'd0) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         S_ERR:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Strobes are flops so the level-sensitive RAM write never sees a glitch.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         mem_Addr   <= '0;
         mem_W_data <= '0;
         mem_R      <= 1'b0;
         mem_W      <= 1'b0;
         op_q       <= OP_FETCH;
         cnt        <= 4'd0;
         ir         <= '0;
         mdr        <= '0;
      end else if (start) begin
         mem_Addr   <= addr_in;
         mem_W_data <= wdata_in;
         op_q       <= op;
         cnt        <= CNT_INIT;
         mem_R      <= (op != OP_STORE);
         mem_W      <= (op == OP_STORE);
      end else if (last) begin
         mem_R <= 1'b0;
         mem_W <= 1'b0;
         if (op_q == OP_FETCH) ir  <= mem_R_data;
         if (op_q == OP_LOAD)  mdr <= mem_R_data;
      end else if (state == S_ACCESS) begin
         cnt <= cnt - 4'd1;
      end
   end

`ifdef MEM_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         fetch_cnt <= '0;
         load_cnt  <= '0;
         store_cnt <= '0;
         err_cnt   <= '0;
      end else if (state == S_DONE) begin
         case (op_q)
            OP_FETCH: fetch_cnt <= fetch_cnt + 32'd1;
            OP_LOAD:  load_cnt  <= load_cnt + 32'd1;
            OP_STORE: store_cnt <= store_cnt + 32'd1;
            default:  ;
         endcase
      end else if (state == S_ERR) begin
         err_cnt <= err_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mc_mem_access.sv
// Directed bench for mc_mem_access: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3, each on its own RAM model.
module tb_mc_mem_access;

   logic        CLK = 1'b0;
   logic        rst1_n, rst3_n;
   logic        req1, req3;
   logic [1:0]  op;
   logic [31:0] addr, wdata;

   logic        busy1, done1, err1, r1, w1;
   logic [31:0] ir1, mdr1, a1, wd1, rd1;
   logic        busy3, done3, err3, r3, w3;
   logic [31:0] ir3, mdr3, a3, wd3, rd3;
`ifdef MEM_PERF_CNT_EN
   logic [31:0] fc1, lc1, sc1, ec1, fc3, lc3, sc3, ec3;
`endif

   logic [31:0] ram1 [256];
   logic [31:0] ram3 [256];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   mc_mem_access #(.WAIT_CYCLES(1)) u1 (
      .CLK(CLK), .RSTn(rst1_n), .req(req1), .op(op), .addr_in(addr), .wdata_in(wdata),
      .busy(busy1), .done(done1), .err(err1), .ir(ir1), .mdr(mdr1),
      .mem_Addr(a1), .mem_R(r1), .mem_W(w1), .mem_W_data(wd1),
`ifdef MEM_PERF_CNT_EN
      .fetch_cnt(fc1), .load_cnt(lc1), .store_cnt(sc1), .err_cnt(ec1),
`endif
      .mem_R_data(rd1));

   mc_mem_access #(.WAIT_CYCLES(3)) u3 (
      .CLK(CLK), .RSTn(rst3_n), .req(req3), .op(op), .addr_in(addr), .wdata_in(wdata),
      .busy(busy3), .done(done3), .err(err3), .ir(ir3), .mdr(mdr3),
      .mem_Addr(a3), .mem_R(r3), .mem_W(w3), .mem_W_data(wd3),
`ifdef MEM_PERF_CNT_EN
      .fetch_cnt(fc3), .load_cnt(lc3), .store_cnt(sc3), .err_cnt(ec3),
`endif
      .mem_R_data(rd3));

   assign rd1 = ram1[a1[9:2]];
   assign rd3 = ram3[a3[9:2]];

   always @(posedge CLK) begin
      if (w1) ram1[a1[9:2]] <= wd1;
      if (w3) ram3[a3[9:2]] <= wd3;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nw;
      logic        saw_done;
      logic [1:0]  bop [4];
      logic [31:0] badr [4];

      for (int i = 0; i < 256; i++) begin
         ram1[i] <= 32'h0;
         ram3[i] <= 32'h0;
      end
      ram1[0] <= 32'h00421821;
      ram1[1] <= 32'h11111111;
      ram1[2] <= 32'h22222222;

      rst1_n = 1'b0; rst3_n = 1'b0;
      req1 = 1'b0; req3 = 1'b0; op = 2'b00; addr = '0; wdata = '0;
      repeat (3) @(negedge CLK);
      rst1_n = 1'b1; rst3_n = 1'b1;
      @(negedge CLK);
      check("rst_busy", {31'b0, busy1}, 32'd0);
      check("rst_done_err", {30'b0, done1, err1}, 32'd0);
      check("rst_strobes", {28'b0, r1, w1, r3, w3}, 32'd0);
      check("rst_ir", ir1, 32'd0);
      check("rst_mdr", mdr1, 32'd0);
      check("rst_addr", a1, 32'd0);
      check("rst_wdata", wd1, 32'd0);

      // Fetch, WAIT_CYCLES=1, addr 0
      req1 = 1'b1; op = 2'b00; addr = 32'h0;
      @(negedge CLK);
      req1 = 1'b0;
      check("f1_memR", {31'b0, r1}, 32'd1);
      check("f1_busy", {31'b0, busy1}, 32'd1);
      check("f1_addr", a1, 32'h0);
      @(negedge CLK);
      check("f1_memR_drop", {31'b0, r1}, 32'd0);
      check("f1_done", {31'b0, done1}, 32'd1);
      check("f1_ir", ir1, 32'h00421821);
      check("f1_mdr", mdr1, 32'd0);
      @(negedge CLK);
      check("f1_done_pulse", {31'b0, done1}, 32'd0);

      // Store 0x3C <- 5, WAIT_CYCLES=3; inputs wiggle during ACCESS
      req3 = 1'b1; op = 2'b10; addr = 32'h3C; wdata = 32'h5;
      @(negedge CLK);
      req3 = 1'b0; addr = 32'h100; wdata = 32'h9;
      check("st_addr", a3, 32'h3C);
      check("st_wdata", wd3, 32'h5);
      nw = 0; saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (w3) nw++;
         if (done3) saw_done = 1'b1;
         @(negedge CLK);
      end
      check("st_memW_cycles", nw, 32'd3);
      check("st_done_seen", {31'b0, saw_done}, 32'd1);
      check("st_ram", ram3[15], 32'h5);
      check("st_addr_hold", a3, 32'h3C);

      // Load 0x3C
      req3 = 1'b1; op = 2'b01; addr = 32'h3C;
      @(negedge CLK);
      req3 = 1'b0;
      check("ld_memR", {31'b0, r3}, 32'd1);
      repeat (3) @(negedge CLK);
      check("ld_done", {31'b0, done3}, 32'd1);
      check("ld_mdr", mdr3, 32'h5);
      check("ld_ir", ir3, 32'd0);

      // Misaligned load
      req1 = 1'b1; op = 2'b01; addr = 32'h3E;
      @(negedge CLK);
      req1 = 1'b0;
      check("e1_err", {31'b0, err1}, 32'd1);
      check("e1_strobes", {30'b0, r1, w1}, 32'd0);
      check("e1_busy", {31'b0, busy1}, 32'd0);
      @(negedge CLK);
      check("e1_err_pulse", {31'b0, err1}, 32'd0);
      check("e1_mdr", mdr1, 32'd0);
      check("e1_addr", a1, 32'h0);

      // Out-of-range store
      req1 = 1'b1; op = 2'b10; addr = 32'h400; wdata = 32'hDEAD;
      @(negedge CLK);
      req1 = 1'b0;
      check("e2_err", {31'b0, err1}, 32'd1);
      check("e2_memW", {31'b0, w1}, 32'd0);
      @(negedge CLK);
      check("e2_wdata", wd1, 32'd0);

      // Reserved op
      req1 = 1'b1; op = 2'b11; addr = 32'h8;
      @(negedge CLK);
      req1 = 1'b0;
      check("e3_err", {31'b0, err1}, 32'd1);
      @(negedge CLK);
      check("e3_ir", ir1, 32'h00421821);

      // Reset during the 2nd ACCESS cycle of a store
      req3 = 1'b1; op = 2'b10; addr = 32'h10; wdata = 32'hAA;
      @(negedge CLK);
      req3 = 1'b0;
      @(negedge CLK);
      check("rm_memW_before", {31'b0, w3}, 32'd1);
      #1 rst3_n = 1'b0;
      #1;
      check("rm_memW_async", {31'b0, w3}, 32'd0);
      check("rm_busy", {31'b0, busy3}, 32'd0);
      @(negedge CLK);
      check("rm_no_done", {30'b0, done3, err3}, 32'd0);
      rst3_n = 1'b1;
      req3 = 1'b1; op = 2'b00; addr = 32'h10;
      @(negedge CLK);
      req3 = 1'b0;
      repeat (3) @(negedge CLK);
      check("rm_fetch_done", {31'b0, done3}, 32'd1);
      check("rm_fetch_ir", ir3, 32'hAA);

      // Back-to-back alternating fetch/load with req held high
      rst1_n = 1'b0;
      @(negedge CLK);
      rst1_n = 1'b1;
      bop[0] = 2'b00; badr[0] = 32'h4;
      bop[1] = 2'b01; badr[1] = 32'h8;
      bop[2] = 2'b00; badr[2] = 32'h4;
      bop[3] = 2'b01; badr[3] = 32'h8;
      req1 = 1'b1; op = bop[0]; addr = badr[0];
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("bb_busy", {31'b0, busy1}, 32'd1);
         if (i < 3) begin
            op = bop[i+1]; addr = badr[i+1];
         end else begin
            req1 = 1'b0;
         end
         @(negedge CLK);
         check("bb_done", {31'b0, done1}, 32'd1);
         if (bop[i] == 2'b00) check("bb_ir", ir1, 32'h11111111);
         else                 check("bb_mdr", mdr1, 32'h22222222);
         @(negedge CLK);
         check("bb_idle", {30'b0, done1, busy1}, 32'd0);
      end
`ifdef MEM_PERF_CNT_EN
      check("pc_fetch", fc1, 32'd2);
      check("pc_load", lc1, 32'd2);
      check("pc_store", sc1, 32'd0);
      check("pc_err", ec1, 32'd0);
      check("pc3_store", sc3, 32'd0);
      check("pc3_fetch", fc3, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
